ram_cache_bridge: RTL and testbench
===================================

# ram_cache_bridge

Parametrised block-refill/write-back bridge between a cache that moves whole blocks and a word-wide RAM. It is the next-generation glue layer: data width and block size are configurable, and a state machine replaces free-running counting. The request is captured at acceptance, so the cache may change its inputs mid-transfer. Per-beat RAM wait states are absorbed and read data is registered. Completion is signalled by a single-cycle `mem_miss` low, and a dropped request aborts the transfer cleanly. It sits between the L1 cache controller and the RAM memory model in the 1-stage core.

## Interface
- `BLOCKS`, 4: words per cache block; power of 2, ≥2.
- `XLEN`, 32: word width in bits; multiple of 8.
- `ADDR_W`, 32: byte-address width.
- Derived: `OFF = $clog2(XLEN/8)`, `CW = $clog2(BLOCKS)`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `mem_req` in 1: cache block request; held high until the done cycle.
- `mem_addr` in ADDR_W: any byte address inside the target block.
- `mem_we` in 1: 1 = write block to RAM; 0 = refill from RAM.
- `mem_write_block` in BLOCKS×XLEN: block to write; word i goes to block offset i.
- `mem_read_block` out BLOCKS×XLEN: refilled block; word i comes from block offset i.
- `mem_miss` out 1: stall to the cache; low for exactly one cycle when the transfer completes.
- `ram_req` out 1: RAM beat request.
- `ram_addr` out ADDR_W: word-aligned beat address.
- `ram_we` out 1: beat write enable.
- `ram_write_word` out XLEN: beat write data.
- `ram_read_word` in XLEN: beat read data, valid when `ram_req & !ram_we & !ram_miss`.
- `ram_miss` in 1: RAM wait state; the beat is not accepted this cycle.

## Operation
The bridge has three states: IDLE, XFER, DONE.

**Registers**
- `base_q`: `mem_addr[ADDR_W-1:CW+OFF]`.
- `we_q`: captured `mem_we`.
- `wblk_q`: captured `mem_write_block`.
- `cnt`: CW-bit beat counter.
- `rbuf`: BLOCKS×XLEN read buffer.

**IDLE**
- `ram_req` = 0; `mem_miss` = `mem_req`.
- On `mem_req` = 1: capture `base_q`, `we_q`, `wblk_q` (the latter only when `mem_we` = 1); set `cnt` = 0; go to XFER.

**XFER**
- `mem_miss` = 1; `ram_req` = `mem_req`; `ram_we` = `we_q`.
- `ram_addr` = {`base_q`, `cnt`, OFF'b0}.
- `ram_write_word` = `we_q` ? `wblk_q[cnt]` : 0.
- Beat accepted when `mem_req & !ram_miss`:
  - On a read, `rbuf[cnt]` ← `ram_read_word`.
  - If `cnt` == BLOCKS-1, go to DONE; otherwise `cnt`++.
- `ram_miss` = 1: hold `cnt`, address and data.
- `mem_req` = 0 (abort): go to IDLE with no done cycle. `rbuf` keeps any partial data. Beats already written to RAM are not undone.

**DONE**
- `mem_miss` = 0 and `ram_req` = 0 for this one cycle.
- `mem_read_block` = `rbuf` on a read, 0 on a write.
- Always go to IDLE next. If `mem_req` is still high in IDLE, a new transfer starts; the cache must drop or change its request after sampling DONE.

**Output outside DONE**
- `mem_read_block` = 0.

**Reset values**
- State = IDLE; `cnt`, `base_q`, `we_q`, `wblk_q`, `rbuf` = 0.
- Outputs: `ram_req` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_write_word` = 0, `mem_read_block` = 0.
- `mem_miss` = `mem_req`.
- Reset asserted mid-XFER drops `ram_req` immediately, combinationally via state.

## Timing
- A request accepted in IDLE at cycle 0 issues beats in cycles 1..BLOCKS, with each wait state adding 1 cycle. DONE follows in the cycle after the last accepted beat.
- Zero-wait latency: `mem_miss` is low in cycle BLOCKS+1 (cycle 5 for BLOCKS = 4).
- Beats are issued strictly in ascending order 0..BLOCKS-1; there is no critical-word-first ordering.
- `cnt` wraps only through the DONE→IDLE reset to 0; it never increments past BLOCKS-1.
- Changes on `mem_addr`, `mem_we` or `mem_write_block` after cycle 0 have no effect on the transfer in flight.

## Test plan
- **Zero-wait refill:** reset, then read at `mem_addr` = 0x0000_0104 with BLOCKS = 4, RAM returning the address as data.
  - `ram_addr` = 0x100, 0x104, 0x108, 0x10C in cycles 1–4.
  - `mem_miss` is low only in cycle 5, with `mem_read_block` = {0x10C, 0x108, 0x104, 0x100}.
- **Wait states:** same read with `ram_miss` = 1 in cycles 2 and 3.
  - `ram_addr` holds at 0x104 for 3 cycles.
  - Done cycle moves to 7; data is unchanged.
- **Write-back:** write block {D3, D2, D1, D0} at 0x200, with `mem_write_block` changed to garbage after cycle 0.
  - `ram_write_word` = D0..D3 at 0x200..0x20C with `ram_we` = 1.
  - `mem_read_block` = 0 in the done cycle.
- **Abort:** drop `mem_req` in cycle 2 of a read.
  - `ram_req` = 0 the same cycle; state is IDLE next cycle; no cycle with `mem_miss` low while `mem_req` was high.
  - A new read at 0x300 then completes normally.
- **Async reset:** assert `reset` mid-XFER between clock edges.
  - `ram_req`, `ram_addr` and `mem_read_block` go to 0 before the next edge.
- **Parametrisation:** BLOCKS = 8, XLEN = 64.
  - 8 beats at addresses base+0x00..0x38 in steps of 8.
  - Done at cycle 9.

Source files
------------

// File: rtl/ram_cache_bridge.sv
// Block refill / write-back bridge between a block-wide cache port and a word-wide RAM.
// Beats issue in ascending order from a captured request; RAM wait states stall, mem_req low aborts.
module ram_cache_bridge #(
  parameter int BLOCKS = 4,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_req,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_we,
  input  logic [BLOCKS*XLEN-1:0]   mem_write_block,
  output logic [BLOCKS*XLEN-1:0]   mem_read_block,
  output logic                     mem_miss,
  output logic                     ram_req,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [XLEN-1:0]          ram_write_word,
  input  logic [XLEN-1:0]          ram_read_word,
  input  logic                     ram_miss
);
  localparam int OFF  = $clog2(XLEN / 8);
  localparam int CW   = $clog2(BLOCKS);
  localparam int BW   = ADDR_W - CW - OFF;
  localparam int BLKW = BLOCKS * XLEN;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     base_q, base_d;
  logic              we_q, we_d;
  logic [BLKW-1:0]   wblk_q, wblk_d;
  logic [BLKW-1:0]   rbuf_q, rbuf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_beat;
  logic              unused_addr_bits;

  // Offset bits inside the block are irrelevant: beats always start at word 0.
  assign unused_addr_bits = &{1'b0, mem_addr[CW+OFF-1:0]};
  assign last_beat        = (cnt_q == CW'(BLOCKS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      we_q    <= 1'b0;
      wblk_q  <= '0;
      rbuf_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      we_q    <= we_d;
      wblk_q  <= wblk_d;
      rbuf_q  <= rbuf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    we_d           = we_q;
    wblk_d         = wblk_q;
    rbuf_d         = rbuf_q;
    cnt_d          = cnt_q;
    mem_miss       = mem_req;
    mem_read_block = '0;
    ram_req        = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_write_word = '0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          base_d = mem_addr[ADDR_W-1:CW+OFF];
          we_d   = mem_we;
          if (mem_we) wblk_d = mem_write_block;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        mem_miss       = 1'b1;
        ram_req        = mem_req;
        ram_we         = we_q;
        ram_addr       = ADDR_W'({base_q, cnt_q}) << OFF;
        ram_write_word = we_q ? wblk_q[int'(cnt_q)*XLEN +: XLEN] : '0;
        if (!mem_req) begin
          // Abort: partial read data stays in rbuf, no done cycle.
          state_d = IDLE;
        end else if (!ram_miss) begin
          if (!we_q) rbuf_d[int'(cnt_q)*XLEN +: XLEN] = ram_read_word;
          if (last_beat) state_d = DONE;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        mem_miss       = 1'b0;
        mem_read_block = we_q ? '0 : rbuf_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram_cache_bridge.sv
// Bench for ram_cache_bridge: transaction-level beat/block model plus directed literal checks,
// run against a 4x32 and an 8x64 instance.
`timescale 1ns/1ps
module tb_ram_cache_bridge;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         sel8;
  logic         mem_req, mem_we, ram_miss;
  logic [31:0]  mem_addr;
  logic [511:0] wblk;

  logic         mem_miss4, ram_req4, ram_we4;
  logic [31:0]  ram_addr4, ram_ww4, ram_rw4;
  logic [127:0] rblk4;
  logic         mem_miss8, ram_req8, ram_we8;
  logic [31:0]  ram_addr8;
  logic [63:0]  ram_ww8, ram_rw8;
  logic [511:0] rblk8;

  // RAM returns the beat address as data (upper half inverted on the wide instance).
  assign ram_rw4 = ram_addr4;
  assign ram_rw8 = {~ram_addr8, ram_addr8};

  ram_cache_bridge #(.BLOCKS(4), .XLEN(32), .ADDR_W(32)) dut4 (
    .clock(clock), .reset(reset), .mem_req(mem_req & ~sel8), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_write_block(wblk[127:0]), .mem_read_block(rblk4),
    .mem_miss(mem_miss4), .ram_req(ram_req4), .ram_addr(ram_addr4), .ram_we(ram_we4),
    .ram_write_word(ram_ww4), .ram_read_word(ram_rw4), .ram_miss(ram_miss));

  ram_cache_bridge #(.BLOCKS(8), .XLEN(64), .ADDR_W(32)) dut8 (
    .clock(clock), .reset(reset), .mem_req(mem_req & sel8), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_write_block(wblk), .mem_read_block(rblk8),
    .mem_miss(mem_miss8), .ram_req(ram_req8), .ram_addr(ram_addr8), .ram_we(ram_we8),
    .ram_write_word(ram_ww8), .ram_read_word(ram_rw8), .ram_miss(ram_miss));

  logic         c_ram_req, c_ram_we, c_mem_miss;
  logic [31:0]  c_ram_addr;
  logic [63:0]  c_ram_ww;
  logic [511:0] c_rblk;
  assign c_ram_req  = sel8 ? ram_req8  : ram_req4;
  assign c_ram_we   = sel8 ? ram_we8   : ram_we4;
  assign c_mem_miss = sel8 ? mem_miss8 : mem_miss4;
  assign c_ram_addr = sel8 ? ram_addr8 : ram_addr4;
  assign c_ram_ww   = sel8 ? ram_ww8   : {32'h0, ram_ww4};
  assign c_rblk     = sel8 ? rblk8     : {384'h0, rblk4};

  int n_pass = 0;
  int n_total = 0;
  int done_seen = 0;

  logic [31:0]  q_addr[$];
  logic [63:0]  q_wd[$];
  logic         m_we;
  logic [511:0] m_blk;

  logic [31:0]  log_addr[0:31];
  logic [63:0]  log_wd[0:31];
  logic         log_we[0:31];
  logic [511:0] done_blk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected beat sequence and done-cycle block for one transfer.
  task automatic model_setup(input bit b8, input logic [31:0] addr, input bit we,
                             input logic [511:0] wb);
    int nb, step;
    logic [31:0] base, a;
    nb   = b8 ? 8 : 4;
    step = b8 ? 8 : 4;
    base = addr & ~(32'(nb * step) - 32'd1);
    q_addr.delete();
    q_wd.delete();
    m_we  = we;
    m_blk = '0;
    for (int i = 0; i < nb; i++) begin
      a = base + 32'(i * step);
      q_addr.push_back(a);
      if (b8) begin
        q_wd.push_back(wb[i*64 +: 64]);
        if (!we) m_blk[i*64 +: 64] = {~a, a};
      end else begin
        q_wd.push_back({32'h0, wb[i*32 +: 32]});
        if (!we) m_blk[i*32 +: 32] = a;
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (c_ram_req) begin
        chk("beat_expected", 512'(q_addr.size() != 0), 512'd1);
        if (q_addr.size() != 0) begin
          chk("beat_addr", c_ram_addr, q_addr[0]);
          chk("beat_we", c_ram_we, m_we);
          chk("beat_wdata", c_ram_ww, m_we ? q_wd[0] : 64'h0);
          if (!ram_miss) begin
            void'(q_addr.pop_front());
            void'(q_wd.pop_front());
          end
        end
      end
      if (mem_req && !c_mem_miss) begin
        done_seen++;
        chk("done_all_beats", 512'(q_addr.size()), 512'd0);
        chk("done_block", c_rblk, m_blk);
      end else begin
        chk("block_zero", c_rblk, 512'd0);
      end
    end
  end

  task automatic run(input bit b8, input logic [31:0] addr, input bit we, input logic [511:0] wb,
                     input logic [31:0] miss_mask, input int abort_at, output int done_cyc);
    model_setup(b8, addr, we, wb);
    sel8     = b8;
    mem_req  = 1'b1;
    mem_addr = addr;
    mem_we   = we;
    wblk     = wb;
    ram_miss = miss_mask[0];
    done_cyc = -1;
    done_blk = '0;
    for (int c = 1; c < 32 && done_cyc < 0; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin
        mem_addr = ~addr;
        mem_we   = ~we;
        wblk     = {16{32'hDEADBEEF}};
      end
      ram_miss = miss_mask[c];
      if (c == abort_at) mem_req = 1'b0;
      @(negedge clock);
      log_addr[c] = c_ram_addr;
      log_wd[c]   = c_ram_ww;
      log_we[c]   = c_ram_we;
      if (c == abort_at) begin
        chk("abort_req_drop", 512'(c_ram_req), 512'd0);
        break;
      end
      if (!c_mem_miss) begin
        done_cyc = c;
        done_blk = c_rblk;
      end
    end
    if (abort_at < 0) chk("done_within_budget", 512'(done_cyc >= 0), 512'd1);
    @(posedge clock); #1;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ram_miss = 1'b0;
    if (abort_at >= 0) begin
      q_addr.delete();
      q_wd.delete();
    end
  endtask

  initial begin
    int dc, seen0;
    logic [511:0] wb;
    reset = 1'b1; sel8 = 1'b0; mem_req = 1'b0; mem_we = 1'b0; ram_miss = 1'b0;
    mem_addr = '0; wblk = '0;
    #12;
    chk("rst_ram_req", 512'(ram_req4), 512'd0);
    chk("rst_ram_addr", 512'(ram_addr4), 512'd0);
    chk("rst_ram_we", 512'(ram_we4), 512'd0);
    chk("rst_ram_wword", 512'(ram_ww4), 512'd0);
    chk("rst_read_block", 512'(rblk4), 512'd0);
    chk("rst_mem_miss_lo", 512'(mem_miss4), 512'd0);
    chk("rst_ram_req8", 512'(ram_req8), 512'd0);
    mem_req = 1'b1; #1;
    chk("rst_mem_miss_hi", 512'(mem_miss4), 512'd1);
    mem_req = 1'b0;
    @(posedge clock); #1 reset = 1'b0;

    // Zero-wait refill
    run(1'b0, 32'h0000_0104, 1'b0, 512'd0, 32'h0, -1, dc);
    chk("zw_done_cycle", 512'(dc), 512'd5);
    for (int i = 1; i <= 4; i++)
      chk("zw_addr", 512'(log_addr[i]), 512'(32'h100 + 32'((i - 1) * 4)));
    chk("zw_block", done_blk, {384'h0, 32'h10C, 32'h108, 32'h104, 32'h100});

    // Wait states in cycles 2 and 3
    run(1'b0, 32'h0000_0104, 1'b0, 512'd0, 32'b1100, -1, dc);
    chk("ws_done_cycle", 512'(dc), 512'd7);
    chk("ws_hold_c2", 512'(log_addr[2]), 512'h104);
    chk("ws_hold_c3", 512'(log_addr[3]), 512'h104);
    chk("ws_hold_c4", 512'(log_addr[4]), 512'h104);
    chk("ws_block", done_blk, {384'h0, 32'h10C, 32'h108, 32'h104, 32'h100});

    // Write-back with inputs garbled after acceptance
    wb = {384'h0, 32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    run(1'b0, 32'h0000_0200, 1'b1, wb, 32'h0, -1, dc);
    chk("wb_done_cycle", 512'(dc), 512'd5);
    chk("wb_w0", 512'(log_wd[1]), 512'hD0D0_0000);
    chk("wb_w3", 512'(log_wd[4]), 512'hD3D3_0003);
    chk("wb_addr3", 512'(log_addr[4]), 512'h20C);
    chk("wb_we", 512'(log_we[2]), 512'd1);
    chk("wb_block_zero", done_blk, 512'd0);

    // Abort in cycle 2, then a clean read at 0x300
    seen0 = done_seen;
    run(1'b0, 32'h0000_0100, 1'b0, 512'd0, 32'h0, 2, dc);
    @(negedge clock);
    chk("abort_idle_miss", 512'(c_mem_miss), 512'd0);
    chk("abort_idle_req", 512'(c_ram_req), 512'd0);
    chk("abort_no_done", 512'(done_seen), 512'(seen0));
    @(posedge clock); #1;
    run(1'b0, 32'h0000_0300, 1'b0, 512'd0, 32'h0, -1, dc);
    chk("post_abort_done", 512'(dc), 512'd5);
    chk("post_abort_block", done_blk, {384'h0, 32'h30C, 32'h308, 32'h304, 32'h300});

    // Async reset between edges mid-transfer
    model_setup(1'b0, 32'h0000_0100, 1'b0, 512'd0);
    sel8 = 1'b0; mem_req = 1'b1; mem_addr = 32'h100; mem_we = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("pre_reset_req", 512'(ram_req4), 512'd1);
    chk("pre_reset_addr", 512'(ram_addr4), 512'h104);
    #2 reset = 1'b1;
    #1;
    chk("arst_ram_req", 512'(ram_req4), 512'd0);
    chk("arst_ram_addr", 512'(ram_addr4), 512'd0);
    chk("arst_read_block", 512'(rblk4), 512'd0);
    mem_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    q_addr.delete();
    q_wd.delete();
    @(posedge clock); #1;

    // Wide instance: 8 beats of 64 bits
    run(1'b1, 32'h0000_1014, 1'b0, 512'd0, 32'h0, -1, dc);
    chk("p8_done_cycle", 512'(dc), 512'd9);
    for (int i = 1; i <= 8; i++)
      chk("p8_addr", 512'(log_addr[i]), 512'(32'h1000 + 32'((i - 1) * 8)));
    chk("p8_top_word", 512'(done_blk[511:448]), 512'({~32'h1038, 32'h1038}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
